// File: rtl/aes_io_if.sv
// Byte-stream handshakes of the AES I/O front end: s_* carries bytes in, m_* carries bytes out.
// The slave modport is the unit's view; master is the environment's view.
interface aes_io_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;

  modport slave  (input  s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, m_ready, input  s_ready, m_valid, m_data);
endinterface

// File: rtl/aes_io_unit.sv
// Byte-serial load (16 plaintext + 16 key bytes) and unload (16 ciphertext bytes) for the AES-128 core.
// Defining AES_IO_KEY_REUSE_EN adds i_reuse_key, which lets a load skip the key bytes.
module aes_io_unit (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_send,
  input  logic [127:0] i_cipher,
`ifdef AES_IO_KEY_REUSE_EN
  input  logic         i_reuse_key,
`endif
  aes_io_if.slave      io,
  output logic         o_data_received,
  output logic         o_done,
  output logic [127:0] o_state,
  output logic [127:0] o_key
);
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_KEY, RX_ACK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_STREAM, TX_ACK} tx_state_t;

  rx_state_t    rx_state, rx_next;
  tx_state_t    tx_state, tx_next;
  logic         load_p1, load_p2, send_p1, send_p2;
  logic [3:0]   rx_cnt, tx_cnt;
  logic [127:0] data_sh, key_sh, tx_sh;
  logic         load_rise, send_rise, rx_hs, tx_hs, rx_last, tx_last, rx_skip_key;

  assign load_rise = load_p1 & ~load_p2;
  assign send_rise = send_p1 & ~send_p2;

  // s_ready drops as soon as the registered load level falls, so no byte is taken during an abort
  assign io.s_ready      = ((rx_state == RX_DATA) || (rx_state == RX_KEY)) && load_p1;
  assign io.m_valid      = (tx_state == TX_STREAM);
  assign io.m_data       = tx_sh[127:120];
  assign o_data_received = (rx_state == RX_ACK);
  assign o_done          = (tx_state == TX_ACK);

  assign rx_hs   = io.s_valid & io.s_ready;
  assign tx_hs   = io.m_valid & io.m_ready;
  assign rx_last = rx_hs & (rx_cnt == 4'd15);
  assign tx_last = tx_hs & (tx_cnt == 4'd15);

`ifdef AES_IO_KEY_REUSE_EN
  logic reuse_p1, key_loaded;
  assign rx_skip_key = reuse_p1 & key_loaded;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reuse_p1   <= 1'b0;
      key_loaded <= 1'b0;
    end else begin
      if ((rx_state == RX_IDLE) && load_rise) reuse_p1 <= i_reuse_key;
      if ((rx_state == RX_KEY) && (rx_next == RX_ACK)) key_loaded <= 1'b1;
    end
  end
`else
  assign rx_skip_key = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (load_rise) rx_next = RX_DATA;
      RX_DATA: begin
        if (!load_p1)     rx_next = RX_IDLE;
        else if (rx_last) rx_next = rx_skip_key ? RX_ACK : RX_KEY;
      end
      RX_KEY: begin
        if (!load_p1)     rx_next = RX_IDLE;
        else if (rx_last) rx_next = RX_ACK;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (send_rise) tx_next = TX_STREAM;
      TX_STREAM: if (tx_last)   tx_next = TX_ACK;
      default:   tx_next = TX_IDLE;
    endcase
  end

  // Stage p1/p2: registered request levels for edge detection, plus byte datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_p1 <= 1'b0;
      load_p2 <= 1'b0;
      send_p1 <= 1'b0;
      send_p2 <= 1'b0;
      rx_cnt  <= 4'd0;
      tx_cnt  <= 4'd0;
      data_sh <= '0;
      key_sh  <= '0;
      tx_sh   <= '0;
      o_state <= '0;
      o_key   <= '0;
    end else begin
      load_p1 <= i_load;
      load_p2 <= load_p1;
      send_p1 <= i_send;
      send_p2 <= send_p1;

      if (rx_state != rx_next) rx_cnt <= 4'd0;
      else if (rx_hs)          rx_cnt <= rx_cnt + 4'd1;
      if (tx_state != tx_next) tx_cnt <= 4'd0;
      else if (tx_hs)          tx_cnt <= tx_cnt + 4'd1;

      if (rx_hs && (rx_state == RX_DATA)) data_sh <= {data_sh[119:0], io.s_data};
      if (rx_hs && (rx_state == RX_KEY))  key_sh  <= {key_sh[119:0], io.s_data};

      // Publish on the final handshake so the outputs are already valid in the ack cycle
      if ((rx_state == RX_DATA) && (rx_next == RX_ACK)) begin
        o_state <= {data_sh[119:0], io.s_data};
      end
      if ((rx_state == RX_KEY) && (rx_next == RX_ACK)) begin
        o_state <= data_sh;
        o_key   <= {key_sh[119:0], io.s_data};
      end

      if ((tx_state == TX_IDLE) && send_rise) tx_sh <= i_cipher;
      else if (tx_hs)                         tx_sh <= {tx_sh[119:0], 8'h00};
    end
  end
endmodule
